// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with show-ahead output.
//
// Reads and writes are level-sensitive enables sampled on the rising edge of clk_i.
// Besides full/empty it reports a fill level and programmable almost-full/almost-empty
// flags, and it supports a synchronous flush and sticky overflow/underflow flags.
//
// Parameters:
//   log2_addr  - address bits, depth = 2**log2_addr (>= 1)
//   data_width - bits per entry
//   af_level   - almost_full_o when level >= af_level (1..depth)
//   ae_level   - almost_empty_o when level <= ae_level (0..depth-1)
//
// Ports:
//   clk_i          - system clock
//   n_reset_i      - synchronous active-low reset
//   flush_i        - synchronous flush, discards contents, keeps error flags
//   data_i, wr_i   - write data / write enable (one entry per cycle)
//   rd_i           - read enable (pop one entry per cycle)
//   data_o         - head-of-queue data, valid while fifo_empty_o = 0
//   fifo_empty_o   - level == 0
//   fifo_full_o    - level == depth
//   almost_empty_o - level <= ae_level
//   almost_full_o  - level >= af_level
//   level_o        - current entry count, 0..depth
//   overflow_o     - sticky: a write was refused
//   underflow_o    - sticky: a read was refused
//   clr_err_i      - clears overflow_o and underflow_o (a new error wins)
module sync_fifo #(
    parameter int unsigned log2_addr  = 3,
    parameter int unsigned data_width = 8,
    parameter int unsigned af_level   = (1 << log2_addr) - 1,
    parameter int unsigned ae_level   = 1
) (
    input  logic                  clk_i,
    input  logic                  n_reset_i,
    input  logic                  flush_i,
    input  logic [data_width-1:0] data_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic [data_width-1:0] data_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic [log2_addr:0]    level_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  clr_err_i
);

    localparam int unsigned depth = 1 << log2_addr;
    localparam logic [log2_addr:0] depth_cnt = (log2_addr + 1)'(depth);
    localparam logic [log2_addr:0] af_cnt    = (log2_addr + 1)'(af_level);
    localparam logic [log2_addr:0] ae_cnt    = (log2_addr + 1)'(ae_level);

    logic [data_width-1:0] mem [depth];

    // Pointers carry one extra bit so they wrap modulo 2*depth.
    logic [log2_addr:0] head_q, head_d;
    logic [log2_addr:0] tail_q, tail_d;
    logic [log2_addr:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic empty, full;
    logic rd_acc, wr_acc;
    logic mem_we;

    assign empty = (count_q == '0);
    assign full  = (count_q == depth_cnt);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_acc      = rd_i & ~empty;
        // A write into a full FIFO is fine when a pop frees a slot the same edge.
        wr_acc      = wr_i & (~full | rd_acc);

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                head_d = head_q + 1'b1;
            end
            if (rd_acc) begin
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q + (log2_addr + 1)'(wr_acc) - (log2_addr + 1)'(rd_acc);

            // Clear first so a fresh error in the same cycle still sets the flag.
            if (clr_err_i) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (wr_i & ~wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_i & ~rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_reset_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; only the pointers define which entries are live.
    assign mem_we = n_reset_i & ~flush_i & wr_acc;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[head_q[log2_addr-1:0]] <= data_i;
        end
    end

    // Unregistered read from the tail keeps the output show-ahead.
    assign data_o         = mem[tail_q[log2_addr-1:0]];
    assign fifo_empty_o   = empty;
    assign fifo_full_o    = full;
    assign almost_empty_o = (count_q <= ae_cnt);
    assign almost_full_o  = (count_q >= af_cnt);
    assign level_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: default-parameter instance driven against a queue
// scoreboard, plus a second instance with a 16-deep, 16-bit configuration.
module tb_sync_fifo;

    logic clk;
    logic n_reset;

    // Instance A: default parameters (depth 8, 8 bits, af 7, ae 1).
    logic       flush_a, wr_a, rd_a, clr_a;
    logic [7:0] data_a_i, data_a_o;
    logic       empty_a, full_a, ae_a, af_a, ov_a, un_a;
    logic [3:0] level_a;

    // Instance B: log2_addr 4, data_width 16, af 12, ae 3.
    logic        wr_b, rd_b;
    logic [15:0] data_b_i, data_b_o;
    logic        empty_b, full_b, ae_b, af_b, ov_b, un_b;
    logic [4:0]  level_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         mov, mun;

    sync_fifo u_dut_a (
        .clk_i          (clk),
        .n_reset_i      (n_reset),
        .flush_i        (flush_a),
        .data_i         (data_a_i),
        .wr_i           (wr_a),
        .rd_i           (rd_a),
        .data_o         (data_a_o),
        .fifo_empty_o   (empty_a),
        .fifo_full_o    (full_a),
        .almost_empty_o (ae_a),
        .almost_full_o  (af_a),
        .level_o        (level_a),
        .overflow_o     (ov_a),
        .underflow_o    (un_a),
        .clr_err_i      (clr_a)
    );

    sync_fifo #(
        .log2_addr  (4),
        .data_width (16),
        .af_level   (12),
        .ae_level   (3)
    ) u_dut_b (
        .clk_i          (clk),
        .n_reset_i      (n_reset),
        .flush_i        (1'b0),
        .data_i         (data_b_i),
        .wr_i           (wr_b),
        .rd_i           (rd_b),
        .data_o         (data_b_o),
        .fifo_empty_o   (empty_b),
        .fifo_full_o    (full_b),
        .almost_empty_o (ae_b),
        .almost_full_o  (af_b),
        .level_o        (level_b),
        .overflow_o     (ov_b),
        .underflow_o    (un_b),
        .clr_err_i      (1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        int n = q.size();
        check("level", 32'(level_a), n);
        check("empty", 32'(empty_a), 32'(n == 0));
        check("full", 32'(full_a), 32'(n == 8));
        check("almost_empty", 32'(ae_a), 32'(n <= 1));
        check("almost_full", 32'(af_a), 32'(n >= 7));
        check("overflow", 32'(ov_a), 32'(mov));
        check("underflow", 32'(un_a), 32'(mun));
        check("full_and_empty", 32'(full_a & empty_a), 0);
    endtask

    // One clock of stimulus on instance A, with the model advanced alongside.
    task automatic step(input logic wr, input logic rd, input logic fl, input logic clr,
                        input logic [7:0] din);
        bit rd_acc, wr_acc;
        wr_a     = wr;
        rd_a     = rd;
        flush_a  = fl;
        clr_a    = clr;
        data_a_i = din;
        if (!n_reset) begin
            q.delete();
            mov = 1'b0;
            mun = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
            rd_acc = rd && (q.size() != 0);
            wr_acc = wr && ((q.size() < 8) || rd_acc);
            if (rd_acc) begin
                check("head_data", 32'(data_a_o), 32'(q[0]));
                void'(q.pop_front());
            end
            if (wr_acc) q.push_back(din);
            if (clr) begin
                mov = 1'b0;
                mun = 1'b0;
            end
            if (wr && !wr_acc) mov = 1'b1;
            if (rd && !rd_acc) mun = 1'b1;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        n_reset  = 1'b0;
        flush_a  = 1'b0;
        wr_a     = 1'b0;
        rd_a     = 1'b0;
        clr_a    = 1'b0;
        data_a_i = '0;
        wr_b     = 1'b0;
        rd_b     = 1'b0;
        data_b_i = '0;
        mov      = 1'b0;
        mun      = 1'b0;

        // Reset values.
        step(0, 0, 0, 0, 8'h00);
        n_reset = 1'b1;
        step(0, 0, 0, 0, 8'h00);

        // Fill 0x01..0x08, then a refused ninth write.
        for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 8'(i));
        step(1, 0, 0, 0, 8'h99);

        // Drain, then one pop too many, then clear errors.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);

        // Simultaneous write and read while full: 0xAA becomes the 8th read.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
        step(1, 1, 0, 0, 8'hAA);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);

        // Simultaneous write and read while empty: write wins, underflow set.
        step(1, 1, 0, 0, 8'h55);
        check("empty_wr_rd_data", 32'(data_a_o), 32'h55);
        step(0, 1, 0, 1, 8'h00);

        // Pointer wrap: 3 in, 3 out, ten times.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) begin
                step(1, 0, 0, 0, 8'(8'h20 + r * 3 + i));
                check("wrap_level_max", 32'(level_a <= 4'd3), 1);
            end
            for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
        end

        // Flush at level 5 with a concurrent write; underflow survives.
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
        step(1, 0, 1, 0, 8'hEE);
        step(1, 0, 0, 0, 8'h77);
        step(0, 1, 0, 0, 8'h00);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
        n_reset = 1'b0;
        step(1, 0, 0, 0, 8'h63);
        n_reset = 1'b1;
        step(0, 0, 0, 0, 8'h00);

        // Second configuration: thresholds, full at 16, 5-bit level.
        check("b_reset_empty", 32'(empty_b), 1);
        for (int i = 1; i <= 16; i++) begin
            wr_b     = 1'b1;
            data_b_i = 16'(16'h0100 + i);
            @(posedge clk);
            #1;
            check("b_level", 32'(level_b), i);
            check("b_almost_empty", 32'(ae_b), 32'(i <= 3));
            check("b_almost_full", 32'(af_b), 32'(i >= 12));
            check("b_full", 32'(full_b), 32'(i == 16));
        end
        wr_b = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rd_b = 1'b1;
            check("b_data", 32'(data_b_o), 32'h0100 + i);
            @(posedge clk);
            #1;
        end
        rd_b = 1'b0;
        check("b_empty", 32'(empty_b), 1);
        check("b_errors", 32'({ov_b, un_b}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the synchronous successor to the team's edge-strobed fifo. Reads and writes are level-sensitive enables sampled on one system clock, so the block can sit directly between CPU-side bus logic and the video/audio/USB datapaths. Beyond full/empty it provides a fill-level count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.

## Interface
- log2_addr, 3, address bits; depth = 2**log2_addr entries (log2_addr >= 1)
- data_width, 8, bits per entry
- af_level, 2**log2_addr-1, almost_full_o asserts when level >= af_level (1..depth)
- ae_level, 1, almost_empty_o asserts when level <= ae_level (0..depth-1)

Ports:
- clk_i  in  1  system clock, all state changes on rising edge
- n_reset_i  in  1  synchronous active-low reset, sampled on rising clk_i
- flush_i  in  1  synchronous flush: discard contents
- data_i  in  data_width  write data
- wr_i  in  1  write enable, one entry per cycle while high
- rd_i  in  1  read enable (pop), one entry per cycle while high
- data_o  out  data_width  show-ahead head-of-queue data, valid while fifo_empty_o=0
- fifo_empty_o  out  1  level == 0
- fifo_full_o  out  1  level == depth
- almost_empty_o  out  1  level <= ae_level
- almost_full_o  out  1  level >= af_level
- level_o  out  log2_addr+1  current entry count, 0..depth
- overflow_o  out  1  sticky: write attempted when not accepted
- underflow_o  out  1  sticky: read attempted when empty
- clr_err_i  in  1  clears overflow_o and underflow_o

## Operation
- Storage: 2**log2_addr x data_width array; head (write) and tail (read) pointers of log2_addr+1 bits; MSB distinguishes full from empty when the low bits match. Pointers wrap modulo 2*depth.
- Flags and level_o are derived from pointers and an internal count register; all outputs are registered or decoded from registers only. There is no combinational path from wr_i/rd_i to any output.
- Accept rules, evaluated per rising edge with n_reset_i=1 and flush_i=0:
  - rd_acc = rd_i & !empty.
  - wr_acc = wr_i & (!full | rd_acc). A write while full is accepted if a pop happens in the same cycle.
  - Empty plus simultaneous wr_i and rd_i: the write is accepted and the read is rejected. There is no bypass; underflow is set.
  - level' = level + wr_acc - rd_acc.
- Errors: overflow set when wr_i & !wr_acc; underflow set when rd_i & !rd_acc. clr_err_i clears both. If a new error occurs in the same cycle as clr_err_i, set wins.
- Flush: head=tail=0, level=0. wr_i and rd_i are ignored that cycle, with no error flags. Sticky error flags are preserved.
- Priority: n_reset_i low > flush_i > normal operation.
- Reset (n_reset_i=0 at an edge, including mid-burst): pointers=0, level_o=0, fifo_empty_o=1, fifo_full_o=0, almost_empty_o=1, almost_full_o=0 (1 only if af_level=0, which is illegal), overflow_o=0, underflow_o=0. Memory contents are not cleared. data_o is don't-care while empty.

## Timing
- Write at edge N: the entry is visible on data_o after edge N if the FIFO was empty. level_o, fifo_empty_o and almost flags update after edge N, giving 1-cycle latency.
- Pop at edge N: data_o shows the next entry after edge N. The consumer samples data_o in the same cycle it asserts rd_i.
- Sustained throughput: 1 write and 1 read per cycle. Full/empty never both asserted.
- Memory: synchronous write. Read is asynchronous from the tail address, mapped to MLAB/registers. The data_o path is not registered, to keep show-ahead behaviour.

## Test plan
- Reset, then 8 writes 0x01..0x08 (default params), 1 per cycle -> level_o 1..8; fifo_full_o=1 after 8th edge; almost_full_o=1 from level 7; ninth write with rd_i=0 -> overflow_o=1, level stays 8, contents unchanged.
- From full, 8 pops -> data_o sequence 0x01..0x08; fifo_empty_o=1 after last; an extra pop sets underflow_o=1; clr_err_i for 1 cycle -> both flags 0.
- Simultaneous wr_i/rd_i when full (data 0xAA) -> level stays 8, no overflow, 0xAA emerges as 8th subsequent read. Simultaneous when empty -> level 1, data_o=written value, underflow_o=1.
- Wrap: 3 writes, 3 reads, repeated 10 times with incrementing data -> ordering preserved across pointer wrap; level never exceeds 3; no error flags.
- Flush at level 5 with wr_i=1 same cycle -> next cycle level_o=0, empty=1, written word discarded; error flags unchanged. Then assert n_reset_i=0 mid-burst -> all outputs at reset values next cycle.
- Params log2_addr=4, data_width=16, af_level=12, ae_level=3 -> almost_empty_o falls at level 4, almost_full_o rises at level 12, full at 16, level_o reads 16 (5 bits).
